// File: rtl/booth_r4_mult_param.sv
// Iterative radix-4 Booth multiplier (signed/unsigned) with start/ready handshake and exact overflow.
// Optional high product half output enabled by defining FULL_PRODUCT_EN.
module booth_r4_mult_param #(
  parameter int WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             start,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             is_signed,
  output logic             busy,
  output logic             ready,
  output logic [WIDTH-1:0] product,
  output logic             overflow
`ifdef FULL_PRODUCT_EN
  ,
  output logic [WIDTH-1:0] product_hi
`endif
);

  localparam int ITER = WIDTH / 2 + 1;
  localparam int XW   = WIDTH + 2;
  localparam int AW   = WIDTH + 4;
  localparam int CW   = $clog2(ITER);

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    CALC = 2'd1,
    DONE = 2'd2
  } state_t;

  state_t            state_r;
  logic [AW-1:0]     acc_r;
  logic [XW-1:0]     m_r;
  logic [XW-1:0]     mcand_r;
  logic              guard_r;
  logic              sgn_r;
  logic [CW-1:0]     cnt_r;
  logic              busy_r;
  logic              ready_r;
  logic [WIDTH-1:0]  product_r;
  logic              overflow_r;
`ifdef FULL_PRODUCT_EN
  logic [WIDTH-1:0]  product_hi_r;
`endif

  logic [AW-1:0]           sel_s;
  logic [AW-1:0]           sum_s;
  logic signed [AW+XW-1:0] pair_s;
  logic [2*WIDTH-1:0]      full_s;

  function automatic logic [XW-1:0] ext_f(input logic [WIDTH-1:0] x, input logic sgn);
    if (sgn) begin
      return {{2{x[WIDTH-1]}}, x};
    end else begin
      return {2'b00, x};
    end
  endfunction

  function automatic logic ovf_f(input logic [2*WIDTH-1:0] p, input logic sgn);
    if (sgn) begin
      return !((&p[2*WIDTH-1:WIDTH-1]) || (~|p[2*WIDTH-1:WIDTH-1]));
    end else begin
      return |p[2*WIDTH-1:WIDTH];
    end
  endfunction

  // Booth digit selection from {m[1], m[0], guard}, widened so +/-2A never wraps
  always_comb begin
    sel_s = '0;
    case ({m_r[1:0], guard_r})
      3'b001, 3'b010: sel_s = {{2{mcand_r[XW-1]}}, mcand_r};
      3'b011:         sel_s = {mcand_r[XW-1], mcand_r, 1'b0};
      3'b100:         sel_s = -({mcand_r[XW-1], mcand_r, 1'b0});
      3'b101, 3'b110: sel_s = -({{2{mcand_r[XW-1]}}, mcand_r});
      default:        sel_s = '0;
    endcase
  end

  // Accumulate then arithmetic-shift the {acc, m} pair right by one Booth digit
  always_comb begin
    sum_s  = acc_r + sel_s;
    pair_s = $signed({sum_s, m_r}) >>> 2'd2;
    full_s = pair_s[2*WIDTH-1:0];
  end

  // Control FSM, datapath registers and registered outputs
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r      <= IDLE;
      acc_r        <= '0;
      m_r          <= '0;
      mcand_r      <= '0;
      guard_r      <= 1'b0;
      sgn_r        <= 1'b0;
      cnt_r        <= '0;
      busy_r       <= 1'b0;
      ready_r      <= 1'b0;
      product_r    <= '0;
      overflow_r   <= 1'b0;
`ifdef FULL_PRODUCT_EN
      product_hi_r <= '0;
`endif
    end else begin
      case (state_r)
        IDLE, DONE: begin
          ready_r <= 1'b0;
          if (start) begin
            mcand_r <= ext_f(a, is_signed);
            m_r     <= ext_f(b, is_signed);
            sgn_r   <= is_signed;
            acc_r   <= '0;
            guard_r <= 1'b0;
            cnt_r   <= '0;
            busy_r  <= 1'b1;
            state_r <= CALC;
          end else begin
            busy_r  <= 1'b0;
            state_r <= IDLE;
          end
        end
        CALC: begin
          acc_r   <= pair_s[AW+XW-1:XW];
          m_r     <= pair_s[XW-1:0];
          guard_r <= m_r[1];
          cnt_r   <= cnt_r + CW'(1);
          if (cnt_r == CW'(ITER - 1)) begin
            busy_r       <= 1'b0;
            ready_r      <= 1'b1;
            product_r    <= full_s[WIDTH-1:0];
            overflow_r   <= ovf_f(full_s, sgn_r);
`ifdef FULL_PRODUCT_EN
            product_hi_r <= full_s[2*WIDTH-1:WIDTH];
`endif
            state_r      <= DONE;
          end else begin
            ready_r <= 1'b0;
          end
        end
        default: begin
          busy_r  <= 1'b0;
          ready_r <= 1'b0;
          state_r <= IDLE;
        end
      endcase
    end
  end

  assign busy     = busy_r;
  assign ready    = ready_r;
  assign product  = product_r;
  assign overflow = overflow_r;
`ifdef FULL_PRODUCT_EN
  assign product_hi = product_hi_r;
`endif

endmodule
